// File: rtl/cdt_ctrl_pkg.sv
// Shared constants for the CDT run/spill control path: default widths and the
// sequencer state encoding.
package cdt_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 12;
  localparam int unsigned LEN_W_DEF = 24;

  // Sequencer state encoding; IDLE is all-zero so reset lands there directly.
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_ARM   = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
  localparam logic [ST_W-1:0] ST_SPILL = 3'd3;
  localparam logic [ST_W-1:0] ST_GAP   = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd5;

  // A new run may only be started when nothing is in flight.
  function automatic logic st_accepts_start(input logic [ST_W-1:0] st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/edge_det.sv
// 1-bit rising-edge detector on a level already synchronous to clk.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_rise
);

  logic r_lvl_d;

  // Previous-cycle copy of the level; cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl_d <= 1'b0;
    end else begin
      r_lvl_d <= i_lvl;
    end
  end

  assign o_rise = i_lvl & ~r_lvl_d;

endmodule

// File: rtl/spill_seq_ctrl.sv
// Run/spill sequencer: arms a run, opens a live window per beam spill, counts
// spills to a latched target, enforces an inter-spill dead gap and an optional
// spill-length timeout. All outputs are registered, so async reset clears them
// immediately.
module spill_seq_ctrl
  import cdt_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned GAP_CYC = 1000
) (
  input  logic             clk,
  input  logic             system_rst_n,
  input  logic             run_start,
  input  logic             run_stop,
  input  logic [CNT_W-1:0] nspill,
  input  logic [LEN_W-1:0] max_len,
  input  logic             in_start,
  input  logic             in_end,
  output logic             live,
  output logic [CNT_W-1:0] spill_cnt,
  output logic             run_busy,
  output logic             run_done,
  output logic             cnt_clear,
  output logic             timeout_err,
  output logic [LEN_W-1:0] last_len
);

  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  logic             w_start_e;
  logic             w_end_e;
  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_state_d;
  logic [CNT_W-1:0] r_tgt;
  logic [LEN_W-1:0] r_max;
  logic [CNT_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_last;
  logic [GAP_W-1:0] r_gap;
  logic             r_terr;
  logic             r_live;
  logic             r_busy;
  logic             r_done;
  logic             r_clr;
  logic             w_latch;
  logic             w_timeout;
  logic             w_spill_take;
  logic             w_gap_last;
  logic [CNT_W-1:0] w_cnt_inc;

  edge_det u_start_edge (
    .clk    (clk),
    .rst_n  (system_rst_n),
    .i_lvl  (in_start),
    .o_rise (w_start_e)
  );

  edge_det u_end_edge (
    .clk    (clk),
    .rst_n  (system_rst_n),
    .i_lvl  (in_end),
    .o_rise (w_end_e)
  );

  // Next-state decode; run_stop beats run_start beats spill end/timeout beats start.
  always_comb begin
    w_state_d    = r_state;
    w_latch      = 1'b0;
    w_cnt_inc    = r_cnt + CNT_W'(1);
    w_gap_last   = (r_gap == GAP_LAST);
    w_timeout    = (r_state == ST_SPILL) && (r_max != '0) && (r_len == r_max);
    // A stop in the exit cycle aborts the spill without counting it.
    w_spill_take = (r_state == ST_SPILL) && (w_end_e || w_timeout) && !run_stop;
    if (run_stop) begin
      w_state_d = ST_IDLE;
    end else if (run_start && st_accepts_start(r_state)) begin
      w_state_d = ST_ARM;
      w_latch   = 1'b1;
    end else begin
      case (r_state)
        ST_ARM:   w_state_d = (r_tgt == '0) ? ST_DONE : ST_WAIT;
        ST_WAIT:  if (w_start_e) w_state_d = ST_SPILL;
        ST_SPILL: if (w_spill_take) w_state_d = (w_cnt_inc == r_tgt) ? ST_DONE : ST_GAP;
        ST_GAP:   if (w_gap_last) w_state_d = ST_WAIT;
        default:  w_state_d = r_state;
      endcase
    end
  end

  // State register and registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_live  <= (w_state_d == ST_SPILL);
      r_busy  <= (w_state_d != ST_IDLE);
      r_done  <= (w_state_d == ST_DONE) && (r_state != ST_DONE);
      r_clr   <= (w_state_d == ST_ARM);
    end
  end

  // Run configuration, spill counter, length capture and sticky timeout flag.
  always_ff @(posedge clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      r_tgt  <= '0;
      r_max  <= '0;
      r_cnt  <= '0;
      r_last <= '0;
      r_terr <= 1'b0;
    end else begin
      if (w_latch) begin
        r_tgt <= nspill;
        r_max <= max_len;
      end
      if ((r_state == ST_ARM) && !run_stop) begin
        r_cnt  <= '0;
        r_terr <= 1'b0;
      end
      if (w_spill_take) begin
        r_cnt  <= w_cnt_inc;
        r_last <= r_len;
        if (w_timeout) r_terr <= 1'b1;
      end
    end
  end

  // Spill length: 1 in the first live cycle, saturating rather than wrapping.
  always_ff @(posedge clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      r_len <= '0;
    end else if ((r_state == ST_WAIT) && (w_state_d == ST_SPILL)) begin
      r_len <= LEN_W'(1);
    end else if ((r_state == ST_SPILL) && !(&r_len)) begin
      r_len <= r_len + LEN_W'(1);
    end
  end

  // Dead-gap counter: idles at zero outside GAP, counts GAP_CYC cycles inside it.
  always_ff @(posedge clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      r_gap <= '0;
    end else if (r_state != ST_GAP) begin
      r_gap <= '0;
    end else if (!w_gap_last) begin
      r_gap <= r_gap + GAP_W'(1);
    end
  end

  assign live        = r_live;
  assign spill_cnt   = r_cnt;
  assign run_busy    = r_busy;
  assign run_done    = r_done;
  assign cnt_clear   = r_clr;
  assign timeout_err = r_terr;
  assign last_len    = r_last;

endmodule

// File: tb/tb_spill_seq_ctrl.sv
// Self-checking bench for spill_seq_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural run/spill model.
module tb_spill_seq_ctrl;

  localparam int CNT_W   = 12;
  localparam int LEN_W   = 24;
  localparam int GAP     = 4;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             system_rst_n;
  logic             run_start, run_stop, in_start, in_end;
  logic [CNT_W-1:0] nspill;
  logic [LEN_W-1:0] max_len;
  logic             live, run_busy, run_done, cnt_clear, timeout_err;
  logic [CNT_W-1:0] spill_cnt;
  logic [LEN_W-1:0] last_len;

  spill_seq_ctrl #(
    .CNT_W   (CNT_W),
    .LEN_W   (LEN_W),
    .GAP_CYC (GAP)
  ) dut (
    .clk          (clk),
    .system_rst_n (system_rst_n),
    .run_start    (run_start),
    .run_stop     (run_stop),
    .nspill       (nspill),
    .max_len      (max_len),
    .in_start     (in_start),
    .in_end       (in_end),
    .live         (live),
    .spill_cnt    (spill_cnt),
    .run_busy     (run_busy),
    .run_done     (run_done),
    .cnt_clear    (cnt_clear),
    .timeout_err  (timeout_err),
    .last_len     (last_len)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_done_seen = 0;

  // Behavioural model of the run, in terms of phases and counts.
  localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_SPILL = 3, P_GAP = 4, P_DONE = 5;
  int m_phase, m_tgt, m_max, m_cnt, m_last, m_len, m_gap_left;
  bit m_terr, m_clr, m_done, m_ps, m_pe;

  task automatic model_reset();
    m_phase = P_IDLE; m_tgt = 0; m_max = 0; m_cnt = 0; m_last = 0; m_len = 0;
    m_gap_left = 0; m_terr = 0; m_clr = 0; m_done = 0; m_ps = 0; m_pe = 0;
  endtask

  task automatic model_edge(input bit s, input bit e, input bit rs, input bit rp,
                            input int ns, input int ml);
    bit se, ee, hit;
    se = s && !m_ps;
    ee = e && !m_pe;
    m_ps = s;
    m_pe = e;
    m_clr = 0;
    m_done = 0;
    if (rp) begin
      m_phase = P_IDLE;
    end else if (rs && (m_phase == P_IDLE || m_phase == P_DONE)) begin
      m_phase = P_ARM; m_tgt = ns; m_max = ml; m_clr = 1;
    end else begin
      case (m_phase)
        P_ARM: begin
          m_cnt = 0; m_terr = 0;
          if (m_tgt == 0) begin m_phase = P_DONE; m_done = 1; end
          else m_phase = P_WAIT;
        end
        P_WAIT: if (se) begin m_phase = P_SPILL; m_len = 1; end
        P_SPILL: begin
          hit = (m_max != 0) && (m_len == m_max);
          if (ee || hit) begin
            if (hit) m_terr = 1;
            m_cnt++;
            m_last = m_len;
            if (m_cnt == m_tgt) begin m_phase = P_DONE; m_done = 1; end
            else begin m_phase = P_GAP; m_gap_left = GAP; end
          end else if (m_len < LEN_MAX) begin
            m_len++;
          end
        end
        P_GAP: begin
          if (m_gap_left == 1) m_phase = P_WAIT;
          else m_gap_left--;
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("live", live, 32'(m_phase == P_SPILL));
    chk("run_busy", run_busy, 32'(m_phase != P_IDLE));
    chk("run_done", run_done, 32'(m_done));
    chk("cnt_clear", cnt_clear, 32'(m_clr));
    chk("spill_cnt", spill_cnt, m_cnt);
    chk("timeout_err", timeout_err, 32'(m_terr));
    chk("last_len", last_len, m_last);
  endtask

  // One clock: drive inputs, step the model at the edge, check #1 later.
  task automatic cyc(input bit s, input bit e, input bit rs, input bit rp);
    in_start = s; in_end = e; run_start = rs; run_stop = rp;
    @(posedge clk);
    model_edge(s, e, rs, rp, int'(nspill), int'(max_len));
    #1;
    check_all();
    if (run_done) n_done_seen++;
  endtask

  initial begin
    system_rst_n = 1'b0;
    {run_start, run_stop, in_start, in_end} = '0;
    nspill = '0;
    max_len = '0;
    model_reset();
    #12;
    chk("rst_live", live, 0);
    chk("rst_busy", run_busy, 0);
    chk("rst_cnt", spill_cnt, 0);
    chk("rst_last", last_len, 0);
    @(negedge clk);
    system_rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // Three clean spills to a target of three.
    nspill = 3; max_len = 0;
    cyc(0, 0, 1, 0);
    chk("t1_clear", cnt_clear, 1);
    cyc(0, 0, 0, 0);
    n_done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0);
      chk("t1_live_on", live, 1);
      repeat (3) cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk("t1_cnt", spill_cnt, k + 1);
      chk("t1_live_off", live, 0);
      repeat (GAP + 1) cyc(0, 0, 0, 0);
    end
    chk("t1_done_pulses", n_done_seen, 1);

    // Timeout: end never rises.
    nspill = 1; max_len = 10;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (9) cyc(1, 0, 0, 0);
    chk("t2_live_still", live, 1);
    cyc(1, 0, 0, 0);
    chk("t2_live_off", live, 0);
    chk("t2_terr", timeout_err, 1);
    chk("t2_last", last_len, 10);
    cyc(0, 0, 0, 0);

    // Start edge inside the gap is dropped.
    nspill = 2; max_len = 0;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    chk("t3_live", live, 0);
    chk("t3_busy", run_busy, 1);
    chk("t3_cnt", spill_cnt, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t3_live_on", live, 1);
    cyc(0, 1, 0, 0);
    chk("t3_cnt2", spill_cnt, 2);
    chk("t3_done", run_done, 1);

    // run_stop mid-spill.
    nspill = 3;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (GAP + 1) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("t4_live", live, 0);
    chk("t4_busy", run_busy, 0);
    chk("t4_cnt", spill_cnt, 1);
    chk("t4_done", run_done, 0);
    cyc(0, 0, 0, 0);

    // Zero target: done straight after the clear pulse.
    nspill = 0;
    cyc(0, 0, 1, 0);
    chk("t5_clear", cnt_clear, 1);
    chk("t5_done_early", run_done, 0);
    cyc(0, 0, 0, 0);
    chk("t5_done", run_done, 1);
    chk("t5_live", live, 0);
    cyc(0, 0, 0, 0);

    // Async reset mid-spill.
    nspill = 2;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("t6_live_pre", live, 1);
    #2;
    system_rst_n = 1'b0;
    #1;
    chk("t6_live", live, 0);
    chk("t6_busy", run_busy, 0);
    chk("t6_cnt", spill_cnt, 0);
    chk("t6_last", last_len, 0);
    model_reset();
    @(negedge clk);
    system_rst_n = 1'b1;
    repeat (3) cyc(1, 0, 0, 0);
    chk("t6_live_after", live, 0);
    chk("t6_busy_after", run_busy, 0);

    // Random traffic against the model.
    begin
      bit s, e, rs, rp;
      s = 1; e = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) s = ~s;
        if ($urandom_range(0, 5) == 0) e = ~e;
        rs = ($urandom_range(0, 29) == 0);
        rp = ($urandom_range(0, 149) == 0);
        nspill = CNT_W'($urandom_range(0, 4));
        max_len = ($urandom_range(0, 2) == 0) ? '0 : LEN_W'($urandom_range(2, 20));
        cyc(s, e, rs, rp);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
